pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU.
- Owns the enable/reset (flush) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Holds the pipeline while a MEM-stage access to the data cache or the AES peripheral completes; inserts load-use bubbles and branch flushes.
- A watchdog aborts hung accesses.

Parameters:
- TIMEOUT_W, 8, width of the access watchdog counter.
- TIMEOUT_CYC, 200, wait cycles before an access is aborted; must be < 2**TIMEOUT_W and >= 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- valid_cache_mem_i  in  1  MEM-stage instruction accesses the data cache
- ready_cache_i  in  1  cache completes the current access (1-cycle pulse or level)
- valid_aes_mem_i  in  1  MEM-stage instruction accesses AES
- ready_aes_i  in  1  AES completes the current access
- load_use_i  in  1  decode hazard: ID instruction needs the load result in EX
- br_taken_i  in  1  branch/jump resolved taken in EX
- req_cache_o  out  1  access request to the cache, held until ready
- req_aes_o  out  1  access request to AES, held until ready
- en_if_o, en_id_o, en_ex_o, en_mem_o  out  1 each  pipeline register / PC enables
- flush_id_o, flush_ex_o  out  1 each  synchronous clear of the ID and EX pipeline registers
- busy_o  out  1  FSM not in IDLE
- timeout_o  out  1  sticky: an access was aborted by the watchdog

Behaviour:
- Reset (rst_ni low): state IDLE, counter 0, timeout_o 0. All enables, flushes and reqs are forced 0 while reset is asserted.

FSM states: IDLE, CACHE_WAIT, AES_WAIT, RELEASE.

IDLE:
- valid_cache_mem_i=1 -> CACHE_WAIT.
- Else valid_aes_mem_i=1 -> AES_WAIT.
- Both valid: cache wins; AES is served after the cache completes only if its valid is still high.
- The cycle the access is detected, all enables are 0 (stall starts with zero bubble).

CACHE_WAIT / AES_WAIT:
- The matching req_*_o is 1; all enables 0; flushes 0.
- The watchdog increments each cycle.
- On the ready of the matching target -> RELEASE; counter cleared.
- Counter == TIMEOUT_CYC-1 with no ready -> RELEASE; timeout_o set; req dropped.
- A ready from the non-requested target is ignored.

RELEASE (exactly 1 cycle):
- All enables 1; req 0.
- valid inputs are ignored in this state: they still describe the completed instruction.
- Next state is IDLE.

IDLE, no access pending:
- br_taken_i=1: all enables 1, flush_id_o=1, flush_ex_o=1. Takes priority over load_use_i.
- Else load_use_i=1: en_if_o=0, en_id_o=0, en_ex_o=1, en_mem_o=1, flush_ex_o=1 (one bubble).
- Else all enables 1, flushes 0.

br_taken_i during a memory stall:
- The EX register is held, so br_taken_i stays asserted.
- The flush is applied in the RELEASE cycle with the same rule as IDLE; flush overrides load_use there too.

Other rules:
- timeout_o clears only on reset.
- busy_o = (state != IDLE).
- Latency: an access with ready on wait cycle k resumes the pipeline after k+2 cycles (detect, k waits, release).

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- When defined, adds three outputs:
  - stall_mem_cnt_o (32 bits): counts cycles with state in CACHE_WAIT or AES_WAIT or the detect cycle.
  - stall_hz_cnt_o (32 bits): counts load-use bubbles.
  - flush_cnt_o (32 bits): counts flush cycles.
- All three saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- cpu_pkg gets typedef enum logic [1:0] stall_state_e {IDLE, CACHE_WAIT, AES_WAIT, RELEASE} and localparam defaults for TIMEOUT_W/TIMEOUT_CYC.
- One sub-module, stall_watchdog: parameterised counter with clear, enable and terminal-count output.

Test Plan:
- Cache load, ready_cache_i on 3rd wait cycle -> enables 0 for 4 cycles, req_cache_o high 3 cycles, then 1 RELEASE cycle with all enables 1, busy_o low after.
- valid_cache_mem_i and valid_aes_mem_i both 1, cache ready after 2, AES ready after 1 -> CACHE_WAIT served first, RELEASE, IDLE, then AES_WAIT entered only if AES valid still high.
- load_use_i=1 for 1 cycle in IDLE -> en_if_o=en_id_o=0, flush_ex_o=1, en_ex_o=en_mem_o=1; next cycle all enables 1.
- br_taken_i=1 and load_use_i=1 together in IDLE -> flush_id_o=flush_ex_o=1, all enables 1; br_taken_i held during a 5-cycle AES stall -> flushes asserted only in the RELEASE cycle.
- TIMEOUT_CYC=4, no ready -> RELEASE after 4 wait cycles, timeout_o=1 and stays 1 through later accesses; rst_ni low mid-CACHE_WAIT -> IDLE, req_cache_o 0, timeout_o 0.
- With PIPE_STALL_PERF_EN: two 3-wait accesses and one bubble -> stall_mem_cnt_o=8, stall_hz_cnt_o=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types, defaults and helpers for the CPU pipeline sequencing logic.
// The flow-control helper encodes the branch-flush / load-use bubble rule.
package cpu_pkg;

  localparam int unsigned TIMEOUT_W_DEF   = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 200;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CACHE_WAIT = 2'd1,
    AES_WAIT   = 2'd2,
    RELEASE    = 2'd3
  } stall_state_e;

  typedef struct packed {
    logic en_if;
    logic en_id;
    logic en_ex;
    logic en_mem;
    logic flush_id;
    logic flush_ex;
  } pipe_ctrl_t;

  // Pipeline controls when no memory access is holding the pipe; branch flush beats load-use.
  function automatic pipe_ctrl_t flow_ctrl(input logic br_taken, input logic load_use);
    pipe_ctrl_t c;
    if (br_taken) begin
      c.en_if    = 1'b1;
      c.en_id    = 1'b1;
      c.en_ex    = 1'b1;
      c.en_mem   = 1'b1;
      c.flush_id = 1'b1;
      c.flush_ex = 1'b1;
    end else if (load_use) begin
      c.en_if    = 1'b0;
      c.en_id    = 1'b0;
      c.en_ex    = 1'b1;
      c.en_mem   = 1'b1;
      c.flush_id = 1'b0;
      c.flush_ex = 1'b1;
    end else begin
      c.en_if    = 1'b1;
      c.en_id    = 1'b1;
      c.en_ex    = 1'b1;
      c.en_mem   = 1'b1;
      c.flush_id = 1'b0;
      c.flush_ex = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Wait-cycle counter for the memory stall; tc flags the last allowed wait
// cycle (count == LIMIT-1) while counting is enabled.
module stall_watchdog #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 200
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_r;

  // Clear wins over enable so every access starts counting from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = en && (cnt_r == LAST);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: memory-access stalls, load-use bubbles, branch flushes.
// Optional performance counters are built when PIPE_STALL_PERF_EN is defined.
module pipe_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_cache_mem_i,
  input  logic        ready_cache_i,
  input  logic        valid_aes_mem_i,
  input  logic        ready_aes_i,
  input  logic        load_use_i,
  input  logic        br_taken_i,
  output logic        req_cache_o,
  output logic        req_aes_o,
  output logic        en_if_o,
  output logic        en_id_o,
  output logic        en_ex_o,
  output logic        en_mem_o,
  output logic        flush_id_o,
  output logic        flush_ex_o,
  output logic        busy_o,
  output logic        timeout_o
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0] stall_mem_cnt_o,
  output logic [31:0] stall_hz_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  stall_state_e state_r;
  stall_state_e state_nxt_s;
  logic         req_cache_r;
  logic         req_aes_r;
  logic         busy_r;
  logic         timeout_r;
  logic         access_s;
  logic         waiting_s;
  logic         wd_clr_s;
  logic         wd_tc_s;
  logic         abort_s;
  pipe_ctrl_t   ctrl_s;

  assign access_s  = valid_cache_mem_i | valid_aes_mem_i;
  assign waiting_s = (state_r == CACHE_WAIT) || (state_r == AES_WAIT);
  assign wd_clr_s  = (state_nxt_s != CACHE_WAIT) && (state_nxt_s != AES_WAIT);

  stall_watchdog #(
    .WIDTH (TIMEOUT_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (wd_clr_s),
    .en     (waiting_s),
    .tc     (wd_tc_s)
  );

  // Next-state decode; a ready arriving together with the terminal count still completes normally.
  always_comb begin
    state_nxt_s = state_r;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_cache_mem_i) begin
          state_nxt_s = CACHE_WAIT;
        end else if (valid_aes_mem_i) begin
          state_nxt_s = AES_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CACHE_WAIT: begin
        if (ready_cache_i) begin
          state_nxt_s = RELEASE;
        end else if (wd_tc_s) begin
          state_nxt_s = RELEASE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = CACHE_WAIT;
        end
      end
      AES_WAIT: begin
        if (ready_aes_i) begin
          state_nxt_s = RELEASE;
        end else if (wd_tc_s) begin
          state_nxt_s = RELEASE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = AES_WAIT;
        end
      end
      RELEASE: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Enables/flushes react in the same cycle so a stall or bubble costs no extra cycle.
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          ctrl_s = '0;
        end else begin
          ctrl_s = flow_ctrl(br_taken_i, load_use_i);
        end
      end
      RELEASE:              ctrl_s = flow_ctrl(br_taken_i, load_use_i);
      CACHE_WAIT, AES_WAIT: ctrl_s = '0;
      default:              ctrl_s = '0;
    endcase
  end

  // State register with the registered request, busy and sticky timeout flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      req_cache_r <= 1'b0;
      req_aes_r   <= 1'b0;
      busy_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      req_cache_r <= (state_nxt_s == CACHE_WAIT);
      req_aes_r   <= (state_nxt_s == AES_WAIT);
      busy_r      <= (state_nxt_s != IDLE);
      timeout_r   <= timeout_r | abort_s;
    end
  end

  assign req_cache_o = req_cache_r;
  assign req_aes_o   = req_aes_r;
  assign busy_o      = busy_r;
  assign timeout_o   = timeout_r;

  // Pipeline controls must be quiet while reset is held, not only after the first edge.
  assign en_if_o    = rst_ni & ctrl_s.en_if;
  assign en_id_o    = rst_ni & ctrl_s.en_id;
  assign en_ex_o    = rst_ni & ctrl_s.en_ex;
  assign en_mem_o   = rst_ni & ctrl_s.en_mem;
  assign flush_id_o = rst_ni & ctrl_s.flush_id;
  assign flush_ex_o = rst_ni & ctrl_s.flush_ex;

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_mem_cnt_r;
  logic [31:0] stall_hz_cnt_r;
  logic [31:0] flush_cnt_r;
  logic        mem_stall_s;
  logic        bubble_s;

  assign mem_stall_s = waiting_s || ((state_r == IDLE) && access_s);
  assign bubble_s    = ctrl_s.flush_ex && !ctrl_s.flush_id;

  // Saturating event counters; a flush cycle is one where the branch flush fires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_mem_cnt_r <= 32'd0;
      stall_hz_cnt_r  <= 32'd0;
      flush_cnt_r     <= 32'd0;
    end else begin
      stall_mem_cnt_r <= mem_stall_s     ? sat_inc(stall_mem_cnt_r) : stall_mem_cnt_r;
      stall_hz_cnt_r  <= bubble_s        ? sat_inc(stall_hz_cnt_r)  : stall_hz_cnt_r;
      flush_cnt_r     <= ctrl_s.flush_id ? sat_inc(flush_cnt_r)     : flush_cnt_r;
    end
  end

  assign stall_mem_cnt_o = stall_mem_cnt_r;
  assign stall_hz_cnt_o  = stall_hz_cnt_r;
  assign flush_cnt_o     = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus randomized
// transactions whose expected cycle-by-cycle behaviour is derived per access.
module tb_pipe_stall_ctrl;

  localparam int unsigned TW   = 8;
  localparam int unsigned TCYC = 6;

  logic clk = 1'b0;
  logic rst_ni;
  logic valid_cache, ready_cache, valid_aes, ready_aes, load_use, br_taken;
  logic req_cache, req_aes, en_if, en_id, en_ex, en_mem, flush_id, flush_ex, busy, timeout;
`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_mem_cnt, stall_hz_cnt, flush_cnt;
`endif

  logic [3:0] en_v;
  logic [1:0] flush_v;
  logic [1:0] req_v;
  assign en_v    = {en_if, en_id, en_ex, en_mem};
  assign flush_v = {flush_id, flush_ex};
  assign req_v   = {req_cache, req_aes};

  int n_checks = 0;
  int n_errors = 0;
  bit exp_to   = 1'b0;
  int exp_mem  = 0;
  int exp_hz   = 0;
  int exp_fl   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .TIMEOUT_W   (TW),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .valid_cache_mem_i (valid_cache),
    .ready_cache_i     (ready_cache),
    .valid_aes_mem_i   (valid_aes),
    .ready_aes_i       (ready_aes),
    .load_use_i        (load_use),
    .br_taken_i        (br_taken),
    .req_cache_o       (req_cache),
    .req_aes_o         (req_aes),
    .en_if_o           (en_if),
    .en_id_o           (en_id),
    .en_ex_o           (en_ex),
    .en_mem_o          (en_mem),
    .flush_id_o        (flush_id),
    .flush_ex_o        (flush_ex),
    .busy_o            (busy),
    .timeout_o         (timeout)
`ifdef PIPE_STALL_PERF_EN
    ,
    .stall_mem_cnt_o   (stall_mem_cnt),
    .stall_hz_cnt_o    (stall_hz_cnt),
    .flush_cnt_o       (flush_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One pipeline cycle with no memory access: branch flush beats load-use bubble.
  task automatic idle_cycle(input bit br, input bit lu);
    step();
    valid_cache = 1'b0; valid_aes = 1'b0; ready_cache = 1'b0; ready_aes = 1'b0;
    br_taken = br; load_use = lu;
    @(negedge clk);
    check_eq("idle_en",    en_v,    br ? 4'hF  : (lu ? 4'b0011 : 4'hF));
    check_eq("idle_flush", flush_v, br ? 2'b11 : (lu ? 2'b01   : 2'b00));
    check_eq("idle_req",   req_v,   2'b00);
    check_eq("idle_busy",  busy,    1'b0);
    check_eq("idle_to",    timeout, exp_to);
    if (br) exp_fl++;
    else if (lu) exp_hz++;
  endtask

  // One access: detect cycle, wait cycles until ready (k) or watchdog expiry, one release cycle.
  // k == 0 means the target never answers.
  task automatic do_access(input bit tgt_aes, input int k, input bit br, input bit other, input bit noise);
    bit aborted;
    int waits;
    int zero_cycles;
    aborted     = (k == 0) || (k > int'(TCYC));
    waits       = aborted ? int'(TCYC) : k;
    zero_cycles = 0;
    step();
    valid_cache = !tgt_aes; valid_aes = tgt_aes | other;
    ready_cache = 1'b0; ready_aes = 1'b0; br_taken = br; load_use = 1'b0;
    @(negedge clk);
    if (en_v == 4'h0) zero_cycles++;
    check_eq("det_flush", flush_v, 2'b00);
    check_eq("det_req",   req_v,   2'b00);
    check_eq("det_busy",  busy,    1'b0);
    for (int j = 1; j <= waits; j++) begin
      step();
      if (tgt_aes) begin
        ready_aes   = (j == k);
        ready_cache = noise & ($urandom_range(0, 1) == 1);
      end else begin
        ready_cache = (j == k);
        ready_aes   = noise & ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      if (en_v == 4'h0) zero_cycles++;
      check_eq("wait_flush", flush_v, 2'b00);
      check_eq("wait_req",   req_v,   tgt_aes ? 2'b01 : 2'b10);
      check_eq("wait_busy",  busy,    1'b1);
      check_eq("wait_to",    timeout, exp_to);
    end
    check_eq("stall_len", zero_cycles, waits + 1);
    exp_mem += waits + 1;
    if (aborted) exp_to = 1'b1;
    step();
    ready_cache = 1'b0; ready_aes = 1'b0;
    @(negedge clk);
    check_eq("rel_en",    en_v,    4'hF);
    check_eq("rel_flush", flush_v, br ? 2'b11 : 2'b00);
    check_eq("rel_req",   req_v,   2'b00);
    check_eq("rel_busy",  busy,    1'b1);
    check_eq("rel_to",    timeout, exp_to);
    if (br) exp_fl++;
  endtask

  initial begin
    rst_ni = 1'b0;
    valid_cache = 1'b0; valid_aes = 1'b0; ready_cache = 1'b0; ready_aes = 1'b0;
    load_use = 1'b0; br_taken = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_en",    en_v,    4'h0);
    check_eq("rst_flush", flush_v, 2'b00);
    check_eq("rst_req",   req_v,   2'b00);
    check_eq("rst_busy",  busy,    1'b0);
    check_eq("rst_to",    timeout, 1'b0);
    br_taken = 1'b0;
    rst_ni = 1'b1;

    idle_cycle(1'b0, 1'b0);
    idle_cycle(1'b0, 1'b1);
    idle_cycle(1'b0, 1'b0);
    idle_cycle(1'b1, 1'b1);
    idle_cycle(1'b1, 1'b0);

    do_access(1'b0, 3, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b0, 1'b0);

    // Both valid: cache first, AES still pending afterwards, stray readies ignored.
    do_access(1'b0, 2, 1'b0, 1'b1, 1'b1);
    do_access(1'b1, 1, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b0, 1'b0);
    // AES valid drops after the cache access: no AES wait may follow.
    do_access(1'b0, 2, 1'b0, 1'b1, 1'b0);
    idle_cycle(1'b0, 1'b0);

    do_access(1'b1, 5, 1'b1, 1'b0, 1'b0);
    idle_cycle(1'b0, 1'b0);

    // Watchdog at the boundary: ready on the last allowed cycle, then one cycle too late.
    do_access(1'b0, int'(TCYC), 1'b0, 1'b0, 1'b0);
    do_access(1'b1, 0, 1'b0, 1'b0, 1'b0);
    do_access(1'b0, 2, 1'b0, 1'b0, 1'b0);
    do_access(1'b1, int'(TCYC) + 1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        idle_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else begin
        do_access($urandom_range(0, 1) == 1, int'($urandom_range(0, TCYC + 2)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
      end
    end

    // Reset in the middle of a cache wait.
    if (!exp_to) do_access(1'b1, 0, 1'b0, 1'b0, 1'b0);
    step();
    valid_cache = 1'b1; valid_aes = 1'b0; br_taken = 1'b1; load_use = 1'b0;
    step();
    step();
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_req",   req_v,   2'b00);
    check_eq("mid_rst_busy",  busy,    1'b0);
    check_eq("mid_rst_to",    timeout, 1'b0);
    check_eq("mid_rst_en",    en_v,    4'h0);
    check_eq("mid_rst_flush", flush_v, 2'b00);
    exp_to = 1'b0; exp_mem = 0; exp_hz = 0; exp_fl = 0;
    @(negedge clk);
    valid_cache = 1'b0; br_taken = 1'b0;
    rst_ni = 1'b1;
    idle_cycle(1'b0, 1'b0);
    do_access(1'b0, 3, 1'b0, 1'b0, 1'b0);
    do_access(1'b1, 3, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b0, 1'b1);
    idle_cycle(1'b0, 1'b0);

`ifdef PIPE_STALL_PERF_EN
    check_eq("perf_mem",   stall_mem_cnt, 32'(exp_mem));
    check_eq("perf_hz",    stall_hz_cnt,  32'(exp_hz));
    check_eq("perf_flush", flush_cnt,     32'(exp_fl));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
